// File: rtl/paddle_input.sv
// Conditions push-buttons or a quadrature encoder into per-frame left/right
// movement requests for the paddle controller.
module paddle_input #(
    parameter int DEBOUNCE_CYCLES = 25175,
    parameter int CNT_WIDTH       = 15,
    parameter int ACC_LIMIT       = 15,
    parameter int STEP            = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_pulse,
    input  logic mode,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    input  logic enc_a,
    input  logic enc_b,
    output logic button_left,
    output logic button_right
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic signed [6:0]    LIM     = 7'(ACC_LIMIT);
    localparam logic signed [6:0]    STP     = 7'(STEP);

    // Bit order: {A, B, right, left}
    logic [3:0] sync1_d, sync1_q, sync2_q;
    logic [1:0] db;

    assign sync1_d = {enc_a, enc_b, btn_right_raw, btn_left_raw};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync1_q;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_debounce
            logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
            logic                 deb_q, deb_d;

            always_comb begin
                cnt_d = cnt_q + 1'b1;
                deb_d = deb_q;
                if (sync2_q[gi] == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_MAX) begin
                    deb_d = sync2_q[gi];
                    cnt_d = '0;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    deb_q <= deb_d;
                end
            end

            assign db[gi] = deb_q;
        end
    endgenerate

    logic [1:0]        ab, prev_ab_q;
    logic signed [6:0] delta;
    logic signed [4:0] acc_q, acc_d;
    logic signed [6:0] acc_wide, adj, sum;
    logic              left_q, left_d, right_q, right_d;

    assign ab = sync2_q[3:2];

    // Gray sequence 00->01->11->10->00 counts up; double-bit jumps are ignored
    always_comb begin
        case ({prev_ab_q, ab})
            4'b0001, 4'b0111, 4'b1110, 4'b1000: delta = 7'sd1;
            4'b0100, 4'b1101, 4'b1011, 4'b0010: delta = -7'sd1;
            default:                            delta = 7'sd0;
        endcase
    end

    always_comb begin
        acc_wide = {{2{acc_q[4]}}, acc_q};
        adj      = 7'sd0;
        left_d   = left_q;
        right_d  = right_q;
        if (frame_pulse) begin
            left_d  = 1'b0;
            right_d = 1'b0;
            if (!mode) begin
                left_d  = db[0] & ~db[1];
                right_d = db[1] & ~db[0];
            end else if (acc_wide >= STP) begin
                right_d = 1'b1;
                adj     = -STP;
            end else if (acc_wide <= -STP) begin
                left_d = 1'b1;
                adj    = STP;
            end
        end
        // The frame decision sees the old acc, but this cycle's delta is still folded in
        sum = acc_wide + delta + adj;
        if (sum > LIM) begin
            sum = LIM;
        end else if (sum < -LIM) begin
            sum = -LIM;
        end
        acc_d = mode ? sum[4:0] : 5'sd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_ab_q <= 2'b00;
            acc_q     <= '0;
            left_q    <= 1'b0;
            right_q   <= 1'b0;
        end else begin
            prev_ab_q <= ab;
            acc_q     <= acc_d;
            left_q    <= left_d;
            right_q   <= right_d;
        end
    end

    assign button_left  = left_q;
    assign button_right = right_q;

endmodule

// File: tb/tb_paddle_input.sv
// Directed bench for paddle_input; per-frame expectations go through a scoreboard queue.
module tb_paddle_input;

    localparam int DB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic frame_pulse = 1'b0;
    logic mode = 1'b0;
    logic btn_left_raw = 1'b0;
    logic btn_right_raw = 1'b0;
    logic enc_a = 1'b0;
    logic enc_b = 1'b0;
    logic button_left, button_right;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];
    logic [1:0] ab_m = 2'b00;

    always #5 clk = ~clk;

    paddle_input #(
        .DEBOUNCE_CYCLES(DB),
        .CNT_WIDTH(5),
        .ACC_LIMIT(15),
        .STEP(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_pulse(frame_pulse),
        .mode(mode),
        .btn_left_raw(btn_left_raw),
        .btn_right_raw(btn_right_raw),
        .enc_a(enc_a),
        .enc_b(enc_b),
        .button_left(button_left),
        .button_right(button_right)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Values are {button_left, button_right}
    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic frame(input string tag, input logic [1:0] expv);
        logic [1:0] e;
        exp_q.push_back(expv);
        frame_pulse = 1'b1;
        step(1);
        frame_pulse = 1'b0;
        e = exp_q.pop_front();
        check(tag, {button_left, button_right}, e);
        $display("frame %s: left=%b right=%b expected=%b", tag, button_left, button_right, e);
    endtask

    function automatic logic [1:0] enc_next(input logic [1:0] s, input bit cw);
        logic [1:0] n;
        if (cw) begin
            case (s)
                2'b00: n = 2'b01;
                2'b01: n = 2'b11;
                2'b11: n = 2'b10;
                default: n = 2'b00;
            endcase
        end else begin
            case (s)
                2'b00: n = 2'b10;
                2'b10: n = 2'b11;
                2'b11: n = 2'b01;
                default: n = 2'b00;
            endcase
        end
        return n;
    endfunction

    task automatic enc(input bit cw, input int n);
        repeat (n) begin
            ab_m = enc_next(ab_m, cw);
            {enc_a, enc_b} = ab_m;
            step(3);
        end
    endtask

    initial begin
        int glitch_len[2];
        glitch_len[0] = 10;
        glitch_len[1] = DB - 1;

        step(2);
        check("reset", {button_left, button_right}, 2'b00);
        rst = 1'b0;
        step(2);

        // 1: right press accepted exactly 2+DB edges after the pin change
        btn_right_raw = 1'b1;
        step(17);
        frame("t1_before_debounce", 2'b00);
        frame("t1_after_debounce", 2'b01);
        step(5);
        check("t1_hold", {button_left, button_right}, 2'b01);

        // 2: short glitches on left are rejected
        for (int i = 0; i < 2; i++) begin
            btn_left_raw = 1'b1;
            step(glitch_len[i]);
            btn_left_raw = 1'b0;
            step(30);
            frame($sformatf("t2_glitch_%0d", glitch_len[i]), 2'b01);
        end

        // 3: both held, then right released
        btn_left_raw = 1'b1;
        step(25);
        frame("t3_both", 2'b00);
        btn_right_raw = 1'b0;
        step(25);
        frame("t3_left_only", 2'b10);
        btn_left_raw = 1'b0;
        step(25);
        frame("t3_none", 2'b00);

        // 4: encoder ignored in mode 0, then 5 cw steps in mode 1
        enc(1'b1, 4);
        mode = 1'b1;
        frame("t4_mode_switch", 2'b00);
        enc(1'b1, 5);
        frame("t4_f1", 2'b01);
        frame("t4_f2", 2'b01);
        frame("t4_f3", 2'b00);
        enc(1'b1, 1);
        frame("t4_residual", 2'b01);
        frame("t4_empty", 2'b00);

        // 5: saturation at -15 then drain
        enc(1'b0, 40);
        for (int i = 0; i < 7; i++) frame($sformatf("t5_drain_%0d", i), 2'b10);
        frame("t5_drain_7", 2'b00);
        enc(1'b0, 1);
        frame("t5_residual", 2'b10);
        frame("t5_empty", 2'b00);

        // 6: transition coincident with frame_pulse, then async reset
        enc(1'b1, 2);
        ab_m = enc_next(ab_m, 1'b0);
        {enc_a, enc_b} = ab_m;
        step(2);
        frame("t6_coincident", 2'b01);
        enc(1'b0, 1);
        frame("t6_acc_minus1", 2'b10);
        enc(1'b1, 3);
        check("t6_pre_reset", {button_left, button_right}, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        check("t6_async_reset", {button_left, button_right}, 2'b00);
        step(2);
        rst = 1'b0;
        step(2);
        enc(1'b1, 1);
        frame("t6_acc_cleared", 2'b00);
        enc(1'b1, 1);
        frame("t6_after_reset", 2'b01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
